// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES signed 32-bit sums into an ACC_W-bit batch total on a valid/ready output.
// Define SUM_ACCUMULATOR_SAT_EN for saturating adds; the default build wraps mod 2^ACC_W.
module sum_accumulator #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 40
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_clear,
  input  logic [31:0]                          i_sum,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [ACC_W-1:0]                     o_acc,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [$clog2(N_SAMPLES+1)-1:0]       o_count
);

  localparam int unsigned CntW = $clog2(N_SAMPLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_SAMPLES - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [ACC_W-1:0]   oacc_q, oacc_d;
  logic               ovalid_q, ovalid_d;
  logic [ACC_W-1:0]   sum_ext;
  logic [ACC_W-1:0]   add_res;

  assign sum_ext = ACC_W'(signed'(i_sum));

`ifdef SUM_ACCUMULATOR_SAT_EN
  localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] add_wide;

  assign add_wide = {acc_q[ACC_W-1], acc_q} + {sum_ext[ACC_W-1], sum_ext};

  // Top two bits disagree only on signed overflow; the wide sign picks the clamp direction.
  always_comb begin
    add_res = add_wide[ACC_W-1:0];
    if (add_wide[ACC_W] != add_wide[ACC_W-1]) begin
      add_res = add_wide[ACC_W] ? MinVal : MaxVal;
    end
  end
`else
  assign add_res = acc_q + sum_ext;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      count_q  <= '0;
      oacc_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      oacc_q   <= oacc_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    oacc_d   = oacc_q;
    ovalid_d = ovalid_q;
    if (i_clear) begin
      // Abort drops any held result but leaves the last total visible on o_acc.
      state_d  = StAccum;
      acc_d    = '0;
      count_d  = '0;
      ovalid_d = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (i_valid) begin
            if (count_q == LastCnt) begin
              oacc_d   = add_res;
              ovalid_d = 1'b1;
              acc_d    = '0;
              count_d  = '0;
              state_d  = StHold;
            end else begin
              acc_d   = add_res;
              count_d = count_q + CntW'(1);
            end
          end
        end
        StHold: begin
          if (i_ready) begin
            ovalid_d = 1'b0;
            state_d  = StAccum;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == StAccum);
    o_acc   = oacc_q;
    o_valid = ovalid_q;
    o_count = count_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus N_SAMPLES=1 and ACC_W=33 instances.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, valid, ready;
  logic [31:0] sum;
  logic        rdy;
  logic [39:0] acc;
  logic        ovld;
  logic [2:0]  cnt;

  logic        valid1;
  logic [31:0] sum1;
  logic        rdy1, ovld1;
  logic [39:0] acc1;
  logic [0:0]  cnt1;

  logic        valid33;
  logic [31:0] sum33;
  logic        rdy33, ovld33;
  logic [32:0] acc33;
  logic [2:0]  cnt33;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(40)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_sum(sum), .i_valid(valid),
    .o_ready(rdy), .o_acc(acc), .o_valid(ovld), .i_ready(ready), .o_count(cnt)
  );

  sum_accumulator #(.N_SAMPLES(1), .ACC_W(40)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_sum(sum1), .i_valid(valid1),
    .o_ready(rdy1), .o_acc(acc1), .o_valid(ovld1), .i_ready(1'b1), .o_count(cnt1)
  );

  sum_accumulator #(.N_SAMPLES(4), .ACC_W(33)) dut33 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_sum(sum33), .i_valid(valid33),
    .o_ready(rdy33), .o_acc(acc33), .o_valid(ovld33), .i_ready(1'b1), .o_count(cnt33)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; ready = 1'b0; sum = '0;
    valid1 = 1'b0; sum1 = '0; valid33 = 1'b0; sum33 = '0;
    #12;
    check("rst_acc", 64'(acc), 64'h0);
    check("rst_valid", 64'(ovld), 64'h0);
    check("rst_count", 64'(cnt), 64'h0);
    check("rst_ready", 64'(rdy), 64'h1);
    rst_n = 1'b1;
    tick();

    // Basic batch 1,2,3,4
    ready = 1'b1; valid = 1'b1;
    sum = 32'd1; tick();
    check("b1_count1", 64'(cnt), 64'd1);
    sum = 32'd2; tick();
    sum = 32'd3; tick();
    check("b1_count3", 64'(cnt), 64'd3);
    sum = 32'd4; tick();
    valid = 1'b0;
    check("b1_valid", 64'(ovld), 64'h1);
    check("b1_acc", 64'(acc), 64'd10);
    check("b1_ready_hold", 64'(rdy), 64'h0);
    check("b1_count_hold", 64'(cnt), 64'h0);
    tick();
    check("b1_drained", 64'(ovld), 64'h0);
    check("b1_ready_back", 64'(rdy), 64'h1);
    check("b1_acc_kept", 64'(acc), 64'd10);

    // Backpressure with {-5,-5,-5,-5}
    ready = 1'b0; valid = 1'b1; sum = 32'hFFFF_FFFB;
    repeat (4) tick();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_acc", 64'(acc), 64'hFF_FFFF_FFEC);
      check("bp_valid", 64'(ovld), 64'h1);
      check("bp_ready", 64'(rdy), 64'h0);
      tick();
    end
    ready = 1'b1;
    tick();
    check("bp_drained", 64'(ovld), 64'h0);

    // Gapped input 7,-,8,-,9,10
    valid = 1'b1; sum = 32'd7; tick();
    check("gap_c1", 64'(cnt), 64'd1);
    valid = 1'b0; sum = 32'hDEAD_BEEF; tick();
    check("gap_c1b", 64'(cnt), 64'd1);
    valid = 1'b1; sum = 32'd8; tick();
    check("gap_c2", 64'(cnt), 64'd2);
    valid = 1'b0; sum = 32'h1234_5678; tick();
    check("gap_c2b", 64'(cnt), 64'd2);
    valid = 1'b1; sum = 32'd9; tick();
    check("gap_c3", 64'(cnt), 64'd3);
    sum = 32'd10; tick();
    valid = 1'b0;
    check("gap_acc", 64'(acc), 64'd34);
    check("gap_valid", 64'(ovld), 64'h1);
    tick();

    // Clear discards the partial batch and the coincident input
    valid = 1'b1; sum = 32'd100;
    tick(); tick();
    check("clr_pre_count", 64'(cnt), 64'd2);
    clear = 1'b1; tick();
    clear = 1'b0;
    check("clr_count", 64'(cnt), 64'd0);
    check("clr_valid", 64'(ovld), 64'h0);
    check("clr_acc_kept", 64'(acc), 64'd34);
    sum = 32'd1;
    repeat (4) tick();
    valid = 1'b0;
    check("clr_acc", 64'(acc), 64'd4);
    check("clr_valid_after", 64'(ovld), 64'h1);
    tick();

    // Asynchronous reset mid-batch
    valid = 1'b1; sum = 32'd50;
    tick(); tick();
    valid = 1'b0;
    rst_n = 1'b0; #2;
    check("arst_count", 64'(cnt), 64'h0);
    check("arst_acc", 64'(acc), 64'h0);
    check("arst_ready", 64'(rdy), 64'h1);
    rst_n = 1'b1;
    tick();

    // Clear together with i_ready while holding
    ready = 1'b0; valid = 1'b1; sum = 32'd3;
    repeat (4) tick();
    valid = 1'b0;
    check("hclr_acc", 64'(acc), 64'd12);
    clear = 1'b1; ready = 1'b1; tick();
    clear = 1'b0;
    check("hclr_valid", 64'(ovld), 64'h0);
    check("hclr_ready", 64'(rdy), 64'h1);
    check("hclr_acc_kept", 64'(acc), 64'd12);

    // N_SAMPLES = 1
    check("n1_ready", 64'(rdy1), 64'h1);
    valid1 = 1'b1; sum1 = 32'h8000_0000; tick();
    valid1 = 1'b0;
    check("n1_acc", 64'(acc1), 64'hFF_8000_0000);
    check("n1_valid", 64'(ovld1), 64'h1);
    check("n1_count", 64'(cnt1), 64'h0);
    tick();
    check("n1_drained", 64'(ovld1), 64'h0);

    // ACC_W = 33 overflow
    valid33 = 1'b1; sum33 = 32'h7FFF_FFFF;
    repeat (4) tick();
    valid33 = 1'b0;
`ifdef SUM_ACCUMULATOR_SAT_EN
    check("w33_acc", 64'(acc33), 64'h0_FFFF_FFFF);
`else
    check("w33_acc", 64'(acc33), 64'h1_FFFF_FFFC);
`endif
    check("w33_valid", 64'(ovld33), 64'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
